frame_ram_arbiter: RTL and testbench
====================================

# frame_ram_arbiter

Shares the single-port frame-buffer BRAM among three requesters: VGA display read, capture write, and effect-engine read/write. The display has fixed top priority. Capture and effect alternate round-robin. While the mode controller's `pause` is high, capture writes are acknowledged and discarded so the capture path never stalls. The block sits between the mode controller, the three pixel datapaths and the frame BRAM.

## Interface
Parameters:
- `ADDR_W`, 17: frame-buffer address width (320x240 frame)
- `DATA_W`, 12: pixel width (RGB444)
- `RD_LAT`, 1: BRAM read latency, in cycles from registered address to `ram_rdata`

Ports:
- `clk` in 1: the single clock; all logic is on the rising edge
- `rst` in 1: synchronous, active-high reset
- `pause` in 1: from the mode controller; blocks capture writes
- `disp_req` in 1; `disp_addr` in ADDR_W: display read request
- `disp_gnt` out 1: display request accepted this cycle
- `disp_rvalid` out 1; `disp_rdata` out DATA_W: display read return
- `cap_req` in 1; `cap_addr` in ADDR_W; `cap_wdata` in DATA_W: capture write request
- `cap_gnt` out 1: capture request accepted this cycle
- `fx_req` in 1; `fx_we` in 1; `fx_addr` in ADDR_W; `fx_wdata` in DATA_W: effect read (`fx_we`=0) or write (`fx_we`=1)
- `fx_gnt` out 1: effect request accepted this cycle
- `fx_rvalid` out 1; `fx_rdata` out DATA_W: effect read return
- `ram_en`, `ram_we` out 1; `ram_addr` out ADDR_W; `ram_wdata` out DATA_W: registered BRAM port
- `ram_rdata` in DATA_W: BRAM read data
- `drop_cnt` out 16: count of capture writes discarded during pause

## Operation
- Request/grant handshake:
  - A requester holds `req` and its address/data stable until it samples `gnt`=1 at a rising edge.
  - `gnt` is combinational from the current requests and the `rr_last` bit.
  - At most one of `disp_gnt`/`fx_gnt`, or a non-paused `cap_gnt`, wins the RAM port per cycle.
- Priority:
  - `disp_req` always wins the port.
  - Otherwise capture and effect alternate. `rr_last` records the last winner between them (CAP or FX). When both request, the one that did not win last is granted.
  - `rr_last` updates only when capture or effect actually wins the RAM port.
- Pause:
  - With `pause`=1 and `cap_req`=1, `cap_gnt`=1 in the same cycle regardless of other requests. No RAM access occurs for it, and the port stays free for display or effect in that cycle.
  - `drop_cnt` increments by 1 and saturates at 0xFFFF.
  - A paused drop does not change `rr_last`.
- RAM port: the winner's `en`/`we`/`addr`/`wdata` are registered into `ram_*` at the granting edge. With no winner, `ram_en`=0 and `ram_we`=0.
- Read return:
  - An owner tag (NONE/DISP/FX) travels through an RD_LAT+1 deep register pipe alongside each access.
  - When the tag emerges, exactly one of `disp_rvalid`/`fx_rvalid` pulses for one cycle, with the matching `*_rdata` = `ram_rdata`.
  - Writes carry the NONE tag and produce no rvalid.
- `disp_rdata`/`fx_rdata` are `ram_rdata` passed through unconditionally. Their value matters only while the matching rvalid is high.

## Timing
- Reset values: `ram_en`=0, `ram_we`=0, `ram_addr`=0, `ram_wdata`=0, `disp_rvalid`=0, `fx_rvalid`=0, `drop_cnt`=0, `rr_last`=FX (capture wins the first tie). All tag-pipe entries reset to NONE.
- Grant latency is 0 cycles: a request is granted in its first cycle when it wins.
- Read latency:
  - Grant in cycle N puts `ram_*` on the port in N+1.
  - The matching rvalid is high in cycle N+1+RD_LAT; with RD_LAT=1, that is N+2.
- Throughput: one RAM access per cycle. Back-to-back display reads are sustained.
- `pause` is sampled in the same cycle as `cap_req`. A request granted before `pause` rose is not retracted.
- Reset mid-operation:
  - Pending tags are flushed to NONE, so no rvalid fires after `rst`.
  - A write already registered on `ram_*` is cancelled in the reset cycle because `ram_en` is cleared.
- Continuous display requests may starve capture and effect indefinitely. This is by design: the display requests at most one access per pixel clock.

## Structure
- Package `frame_ram_pkg`:
  - owner tag constants `OWN_NONE`=2'd0, `OWN_DISP`=2'd1, `OWN_FX`=2'd2
  - round-robin constants `RR_CAP`=1'b0, `RR_FX`=1'b1
  - default widths for `ADDR_W` and `DATA_W`
- Sub-module `rd_tag_pipe`:
  - parameterised by depth (RD_LAT+1) and tag width
  - synchronous clear on `rst`
  - instantiated once

## Test plan
- Reset, then `disp_req` with `disp_addr`=0x00010 while the BRAM model holds 0xABC there → `disp_gnt` in cycle 0, `ram_addr`=0x00010 in cycle 1, `disp_rvalid`=1 with `disp_rdata`=0xABC in cycle 2.
- `cap_req` and `fx_req` (read) held together for 4 cycles, `disp_req`=0 → grants CAP, FX, CAP, FX in order; exactly 2 `fx_rvalid` pulses.
- `disp_req`, `cap_req` and `fx_req` all high for 3 cycles → `disp_gnt` in all 3 cycles; `cap_gnt` and `fx_gnt` stay 0; `rr_last` unchanged.
- `pause`=1 with 5 consecutive `cap_req` cycles plus one `fx_req` write to 0x00100 → 5 `cap_gnt` pulses, `drop_cnt`=5, a single `ram_we` pulse at address 0x00100.
- `drop_cnt` preloaded by driving 65540 paused captures → `drop_cnt` holds at 0xFFFF.
- Assert `rst` in cycle 1 after an `fx_req` read is granted in cycle 0 → no `fx_rvalid` afterwards; all outputs at their reset values in cycle 2.

Source files
------------

// File: rtl/frame_ram_pkg.sv
// Shared constants for the frame-buffer RAM arbiter.
// Owner tags, round-robin encodings and default widths.
package frame_ram_pkg;

  localparam int ADDR_W_DEF = 17;
  localparam int DATA_W_DEF = 12;
  localparam int TAG_W      = 2;

  localparam logic [TAG_W-1:0] OWN_NONE = 2'd0;
  localparam logic [TAG_W-1:0] OWN_DISP = 2'd1;
  localparam logic [TAG_W-1:0] OWN_FX   = 2'd2;

  localparam logic RR_CAP = 1'b0;
  localparam logic RR_FX  = 1'b1;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/rd_tag_pipe.sv
// Shift register carrying the read-owner tag alongside each RAM access.
// Cleared synchronously so no stale return survives a reset.
module rd_tag_pipe #(
  parameter int DEPTH = 2,
  parameter int TAG_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [TAG_W-1:0] tag_in,
  output logic [TAG_W-1:0] tag_out
);

  logic [TAG_W-1:0] pipe_q [DEPTH];
  logic [TAG_W-1:0] pipe_d [DEPTH];

  always_comb begin
    pipe_d[0] = tag_in;
    for (int i = 1; i < DEPTH; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

  assign tag_out = pipe_q[DEPTH-1];

endmodule

// File: rtl/frame_ram_arbiter.sv
// Single-port frame BRAM arbiter: display first, capture/effect
// round-robin, capture writes swallowed while paused.
module frame_ram_arbiter
  import frame_ram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pause,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_gnt,
  output logic              disp_rvalid,
  output logic [DATA_W-1:0] disp_rdata,
  input  logic              cap_req,
  input  logic [ADDR_W-1:0] cap_addr,
  input  logic [DATA_W-1:0] cap_wdata,
  output logic              cap_gnt,
  input  logic              fx_req,
  input  logic              fx_we,
  input  logic [ADDR_W-1:0] fx_addr,
  input  logic [DATA_W-1:0] fx_wdata,
  output logic              fx_gnt,
  output logic              fx_rvalid,
  output logic [DATA_W-1:0] fx_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [15:0]       drop_cnt
);

  logic              ram_en_q, ram_en_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              rr_last_q, rr_last_d;
  logic [15:0]       drop_cnt_q, drop_cnt_d;
  logic [TAG_W-1:0]  tag_in, tag_out;

  logic cap_drop, cap_want;
  logic disp_win, cap_win, fx_win;

  always_comb begin
    cap_drop = cap_req & pause;
    cap_want = cap_req & ~pause;
    disp_win = disp_req;
    cap_win  = ~disp_req & cap_want
             & (~fx_req | (rr_last_q == RR_FX));
    fx_win   = ~disp_req & fx_req
             & (~cap_want | (rr_last_q == RR_CAP));
  end

  assign disp_gnt = disp_win;
  assign cap_gnt  = cap_drop | cap_win;
  assign fx_gnt   = fx_win;

  always_comb begin
    ram_en_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    rr_last_d   = rr_last_q;
    tag_in      = OWN_NONE;
    drop_cnt_d  = cap_drop ? sat_inc16(drop_cnt_q) : drop_cnt_q;
    unique case (1'b1)
      disp_win: begin
        ram_en_d   = 1'b1;
        ram_addr_d = disp_addr;
        tag_in     = OWN_DISP;
      end
      cap_win: begin
        ram_en_d    = 1'b1;
        ram_we_d    = 1'b1;
        ram_addr_d  = cap_addr;
        ram_wdata_d = cap_wdata;
        rr_last_d   = RR_CAP;
      end
      fx_win: begin
        ram_en_d    = 1'b1;
        ram_we_d    = fx_we;
        ram_addr_d  = fx_addr;
        ram_wdata_d = fx_wdata;
        rr_last_d   = RR_FX;
        tag_in      = fx_we ? OWN_NONE : OWN_FX;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      rr_last_q   <= RR_FX;
      drop_cnt_q  <= '0;
    end else begin
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      rr_last_q   <= rr_last_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  rd_tag_pipe #(
    .DEPTH (RD_LAT + 1),
    .TAG_W (TAG_W)
  ) u_tag_pipe (
    .clk     (clk),
    .rst     (rst),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  // Reset also masks the port so an access already on ram_* is dropped.
  assign ram_en    = ram_en_q & ~rst;
  assign ram_we    = ram_we_q & ~rst;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign drop_cnt  = drop_cnt_q;

  assign disp_rvalid = ~rst & (tag_out == OWN_DISP);
  assign fx_rvalid   = ~rst & (tag_out == OWN_FX);
  assign disp_rdata  = ram_rdata;
  assign fx_rdata    = ram_rdata;

endmodule

// File: tb/tb_frame_ram_arbiter.sv
// Bench for frame_ram_arbiter: vector table, corner sequences,
// and randomized traffic against a behavioural reference.
module tb_frame_ram_arbiter;

  localparam int AW = 17;
  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          rst, pause;
  logic          disp_req, disp_gnt, disp_rvalid;
  logic [AW-1:0] disp_addr;
  logic [DW-1:0] disp_rdata;
  logic          cap_req, cap_gnt;
  logic [AW-1:0] cap_addr;
  logic [DW-1:0] cap_wdata;
  logic          fx_req, fx_we, fx_gnt, fx_rvalid;
  logic [AW-1:0] fx_addr;
  logic [DW-1:0] fx_wdata, fx_rdata;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;
  logic [15:0]   drop_cnt;

  frame_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst), .pause(pause),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
    .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
    .cap_req(cap_req), .cap_addr(cap_addr), .cap_wdata(cap_wdata),
    .cap_gnt(cap_gnt),
    .fx_req(fx_req), .fx_we(fx_we), .fx_addr(fx_addr),
    .fx_wdata(fx_wdata), .fx_gnt(fx_gnt),
    .fx_rvalid(fx_rvalid), .fx_rdata(fx_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // BRAM model, 1-cycle read latency; unwritten words hold a pattern
  logic [DW-1:0] mem [1024];
  logic          written [1024];

  function automatic logic [DW-1:0] pat(input int a);
    int v;
    v = a * 37 + 5;
    return (a == 16) ? 12'hABC : v[DW-1:0];
  endfunction

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        mem[ram_addr[9:0]]     <= ram_wdata;
        written[ram_addr[9:0]] <= 1'b1;
      end else begin
        ram_rdata <= written[ram_addr[9:0]] ?
                     mem[ram_addr[9:0]] : pat(int'(ram_addr[9:0]));
      end
    end
  end

  int errs = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    disp_req = 0; cap_req = 0; fx_req = 0; fx_we = 0; pause = 0;
    disp_addr = '0; cap_addr = '0; fx_addr = '0;
    cap_wdata = '0; fx_wdata = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    tick();
    tick();
    rst = 0;
    #1;
    chk("rst_ram_en", ram_en, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    chk("rst_disp_rvalid", disp_rvalid, 0);
    chk("rst_fx_rvalid", fx_rvalid, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
  endtask

  typedef struct {
    logic d, c, f, we, p;
    logic gd, gc, gf;
  } vec_t;

  typedef struct {
    int            due;
    logic          is_disp;
    logic [DW-1:0] data;
  } ret_t;

  vec_t          tbl [14];
  logic [DW-1:0] ref_mem [1024];
  ret_t          rq [$];

  initial begin
    int fx_pulses, cap_cnt, we_cnt, rv_seen;
    logic [AW-1:0] we_addr;

    for (int i = 0; i < 1024; i++) begin
      written[i] = 1'b0;
      mem[i] = '0;
    end
    do_reset();

    // Display read of a preloaded word
    disp_req = 1; disp_addr = 17'h00010;
    #1;
    chk("a_disp_gnt", disp_gnt, 1);
    tick();
    idle();
    #1;
    chk("a_ram_en", ram_en, 1);
    chk("a_ram_we", ram_we, 0);
    chk("a_ram_addr", ram_addr, 17'h00010);
    chk("a_rvalid_early", disp_rvalid, 0);
    tick();
    chk("a_disp_rvalid", disp_rvalid, 1);
    chk("a_disp_rdata", disp_rdata, 12'hABC);
    chk("a_fx_rvalid", fx_rvalid, 0);
    tick();

    //            d  c  f  we p   gd gc gf
    tbl[0]  = '{0, 1, 1, 0, 0,  0, 1, 0};
    tbl[1]  = '{0, 1, 1, 0, 0,  0, 0, 1};
    tbl[2]  = '{0, 1, 1, 0, 0,  0, 1, 0};
    tbl[3]  = '{0, 1, 1, 0, 0,  0, 0, 1};
    tbl[4]  = '{1, 1, 1, 0, 0,  1, 0, 0};
    tbl[5]  = '{1, 1, 1, 0, 0,  1, 0, 0};
    tbl[6]  = '{1, 1, 1, 0, 0,  1, 0, 0};
    tbl[7]  = '{0, 1, 1, 0, 0,  0, 1, 0};
    tbl[8]  = '{1, 1, 0, 0, 1,  1, 1, 0};
    tbl[9]  = '{0, 1, 0, 0, 1,  0, 1, 0};
    tbl[10] = '{0, 1, 1, 0, 0,  0, 0, 1};
    tbl[11] = '{0, 0, 0, 0, 0,  0, 0, 0};
    tbl[12] = '{0, 0, 1, 1, 0,  0, 0, 1};
    tbl[13] = '{0, 1, 0, 0, 0,  0, 1, 0};
    fx_pulses = 0;
    for (int i = 0; i < 14; i++) begin
      disp_req = tbl[i].d; cap_req = tbl[i].c; fx_req = tbl[i].f;
      fx_we = tbl[i].we; pause = tbl[i].p;
      disp_addr = 17'(i + 'h300); cap_addr = 17'(i + 'h200);
      fx_addr = 17'(i); cap_wdata = 12'(i); fx_wdata = 12'(i);
      #1;
      chk($sformatf("tbl%0d_disp_gnt", i), disp_gnt, tbl[i].gd);
      chk($sformatf("tbl%0d_cap_gnt", i), cap_gnt, tbl[i].gc);
      chk($sformatf("tbl%0d_fx_gnt", i), fx_gnt, tbl[i].gf);
      tick();
      if (i < 6 && fx_rvalid) fx_pulses++;
    end
    idle();
    chk("tbl_fx_rvalid_pulses", fx_pulses, 2);
    chk("tbl_drop_cnt", drop_cnt, 2);

    // Paused captures alongside one effect write
    do_reset();
    cap_cnt = 0; we_cnt = 0; we_addr = '0;
    pause = 1;
    for (int k = 0; k < 5; k++) begin
      cap_req = 1; cap_addr = 17'(k); cap_wdata = 12'hFFF;
      fx_req = (k == 0); fx_we = 1;
      fx_addr = 17'h00100; fx_wdata = 12'h123;
      #1;
      if (cap_gnt) cap_cnt++;
      if (k == 0) chk("p_fx_gnt", fx_gnt, 1);
      tick();
      if (ram_en && ram_we) begin
        we_cnt++;
        we_addr = ram_addr;
      end
    end
    idle();
    tick();
    if (ram_en && ram_we) we_cnt++;
    chk("p_cap_gnt_cnt", cap_cnt, 5);
    chk("p_drop_cnt", drop_cnt, 5);
    chk("p_we_pulses", we_cnt, 1);
    chk("p_we_addr", we_addr, 17'h00100);
    chk("p_mem_100", mem[10'h100], 12'h123);

    // Reset while a write is on the port cancels it
    do_reset();
    fx_req = 1; fx_we = 1; fx_addr = 17'h00050; fx_wdata = 12'h777;
    #1;
    chk("c_wr_gnt", fx_gnt, 1);
    tick();
    idle();
    rst = 1;
    #1;
    chk("c_wr_en_masked", ram_en, 0);
    tick();
    rst = 0;
    tick();
    chk("c_wr_cancelled", written[10'h050], 0);

    // Reset after a granted effect read flushes the return
    fx_req = 1; fx_we = 0; fx_addr = 17'h00005;
    #1;
    chk("c_rd_gnt", fx_gnt, 1);
    tick();
    idle();
    rst = 1;
    tick();
    rst = 0;
    #1;
    chk("c_ram_en", ram_en, 0);
    chk("c_ram_we", ram_we, 0);
    chk("c_ram_addr", ram_addr, 0);
    chk("c_ram_wdata", ram_wdata, 0);
    chk("c_disp_rvalid", disp_rvalid, 0);
    chk("c_drop_cnt", drop_cnt, 0);
    rv_seen = 0;
    for (int k = 0; k < 4; k++) begin
      if (fx_rvalid) rv_seen++;
      tick();
    end
    chk("c_no_fx_rvalid", rv_seen, 0);

    // Drop counter saturation
    do_reset();
    pause = 1; cap_req = 1;
    repeat (65534) tick();
    chk("s_drop_before", drop_cnt, 16'hFFFE);
    repeat (6) tick();
    chk("s_drop_sat", drop_cnt, 16'hFFFF);
    idle();

    // Randomized traffic against the reference model
    begin
      int cyc, drop_m, win;
      logic cap_turn, pd, pc, pf;
      logic e_en, e_we;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_wdata;
      logic e_dv, e_fv;
      logic [DW-1:0] e_rd;

      do_reset();
      for (int i = 0; i < 1024; i++)
        ref_mem[i] = written[i] ? mem[i] : pat(i);
      rq.delete();
      cyc = 0; drop_m = 0; cap_turn = 1;
      pd = 0; pc = 0; pf = 0;
      e_addr = '0; e_wdata = '0;
      for (int n = 0; n < 3000; n++) begin
        if (!disp_req || pd) begin
          disp_req = ($urandom_range(3) == 0);
          disp_addr = 17'($urandom_range(1023));
        end
        if (!cap_req || pc) begin
          cap_req = $urandom_range(1);
          cap_addr = 17'($urandom_range(1023));
          cap_wdata = 12'($urandom);
        end
        if (!fx_req || pf) begin
          fx_req = $urandom_range(1);
          fx_we = $urandom_range(1);
          fx_addr = 17'($urandom_range(1023));
          fx_wdata = 12'($urandom);
        end
        pause = ($urandom_range(5) == 0);
        #1;
        // 0 none, 1 display, 2 capture, 3 effect
        win = 0;
        if (disp_req) win = 1;
        else if (cap_req && !pause && fx_req) win = cap_turn ? 2 : 3;
        else if (cap_req && !pause) win = 2;
        else if (fx_req) win = 3;
        chk("r_disp_gnt", disp_gnt, win == 1);
        chk("r_cap_gnt", cap_gnt, (win == 2) || (cap_req && pause));
        chk("r_fx_gnt", fx_gnt, win == 3);
        pd = disp_gnt; pc = cap_gnt; pf = fx_gnt;
        if (cap_req && pause && drop_m < 65535) drop_m++;
        e_en = (win != 0); e_we = 0;
        case (win)
          1: begin
            e_addr = disp_addr;
            rq.push_back('{cyc + 2, 1'b1, ref_mem[disp_addr[9:0]]});
          end
          2: begin
            e_we = 1; e_addr = cap_addr; e_wdata = cap_wdata;
            ref_mem[cap_addr[9:0]] = cap_wdata;
            cap_turn = 0;
          end
          3: begin
            e_we = fx_we; e_addr = fx_addr; cap_turn = 1;
            if (fx_we) begin
              e_wdata = fx_wdata;
              ref_mem[fx_addr[9:0]] = fx_wdata;
            end else begin
              rq.push_back('{cyc + 2, 1'b0, ref_mem[fx_addr[9:0]]});
            end
          end
          default: ;
        endcase
        tick();
        cyc++;
        chk("r_ram_en", ram_en, e_en);
        chk("r_ram_we", ram_we, e_we);
        if (e_en) chk("r_ram_addr", ram_addr, e_addr);
        if (e_we) chk("r_ram_wdata", ram_wdata, e_wdata);
        chk("r_drop_cnt", drop_cnt, drop_m);
        e_dv = 0; e_fv = 0; e_rd = '0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
          e_dv = rq[0].is_disp;
          e_fv = !rq[0].is_disp;
          e_rd = rq[0].data;
          void'(rq.pop_front());
        end
        chk("r_disp_rvalid", disp_rvalid, e_dv);
        chk("r_fx_rvalid", fx_rvalid, e_fv);
        if (e_dv) chk("r_disp_rdata", disp_rdata, e_rd);
        if (e_fv) chk("r_fx_rdata", fx_rdata, e_rd);
      end
      idle();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
